// File: rtl/score_sprite_sched.sv
// -----------------------------------------------------------------------------
// score_sprite_sched
//
// Composites two score digits (player 1 on the left, player 2 on the right) into
// the scan-out stream. The digit images live in a shared synchronous ROM holding
// ten stacked WIDTH*HEIGHT images. A digit whose value changes blinks for
// FLASH_FRAMES frames.
//
// Pipeline (x,y to pixel_out is 3 clocks):
//   edge 1 : rom_addr registered, visible/blank flags captured
//   edge 2 : ROM returns rom_data, flags delayed again
//   edge 3 : pixel_out registered (rom_data, or 0 when hidden/blanked)
//
// Ports
//   pixel_clk  in   1   single clock, all state on the rising edge
//   reset_n    in   1   asynchronous active-low reset
//   vsync      in   1   active-high frame sync level
//   x, y       in   10  current scan position
//   score_p1   in   4   live player 1 score (values above 9 shown as 9)
//   score_p2   in   4   live player 2 score (values above 9 shown as 9)
//   rom_addr   out  16  digit ROM address, held when no sprite is visible
//   rom_data   in   9   ROM pixel, valid one clock after rom_addr is sampled
//   pixel_out  out  9   composited score pixel, 0 when transparent
// -----------------------------------------------------------------------------
module score_sprite_sched #(
  parameter int unsigned P1_X         = 200,
  parameter int unsigned P2_X         = 385,
  parameter int unsigned SCORE_Y      = 20,
  parameter int unsigned WIDTH        = 55,
  parameter int unsigned HEIGHT       = 75,
  parameter int unsigned FLASH_FRAMES = 60
) (
  input  logic        pixel_clk,
  input  logic        reset_n,
  input  logic        vsync,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic [3:0]  score_p1,
  input  logic [3:0]  score_p2,
  output logic [15:0] rom_addr,
  input  logic [8:0]  rom_data,
  output logic [8:0]  pixel_out
);

  typedef enum logic {StIdle, StFlash} flash_st_e;

  localparam logic [15:0] DigitSize = 16'(WIDTH * HEIGHT);
  localparam logic [15:0] RowStride = 16'(WIDTH);
  localparam logic [5:0]  FlashLoad = 6'(FLASH_FRAMES);
  localparam logic [9:0]  P1X10     = 10'(P1_X);
  localparam logic [9:0]  P2X10     = 10'(P2_X);
  localparam logic [9:0]  ScoreY10  = 10'(SCORE_Y);

  // ---------------------------------------------------------------------------
  // Frame start: rising edge of the sampled vsync level
  // ---------------------------------------------------------------------------
  logic r_vsync_prev;
  logic w_frame_start;

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vsync_prev <= 1'b0;
    end else begin
      r_vsync_prev <= vsync;
    end
  end

  assign w_frame_start = vsync & ~r_vsync_prev;

  // ---------------------------------------------------------------------------
  // Per-player shown digit and flash FSM (index 0 = player 1, 1 = player 2)
  // ---------------------------------------------------------------------------
  logic [1:0][3:0] w_score;
  logic [1:0][3:0] w_shown;
  logic [1:0]      w_blank;

  assign w_score = {score_p2, score_p1};

  for (genvar k = 0; k < 2; k++) begin : g_player
    flash_st_e  r_state;
    logic [5:0] r_fcnt;
    logic [3:0] r_shown;
    logic [3:0] w_new;

    assign w_new = (w_score[k] > 4'd9) ? 4'd9 : w_score[k];

    // Shown digit, state and frame counter only move on frame_start. Because
    // reset leaves the shown digit at 0, a score of 0 on the first frame is not
    // a change and does not start a blink.
    always_ff @(posedge pixel_clk or negedge reset_n) begin
      if (!reset_n) begin
        r_state <= StIdle;
        r_fcnt  <= '0;
        r_shown <= '0;
      end else if (w_frame_start) begin
        r_shown <= w_new;
        if (w_new != r_shown) begin
          // A change (re)starts the blink regardless of the current state.
          r_state <= StFlash;
          r_fcnt  <= FlashLoad;
        end else begin
          unique case (r_state)
            StIdle: begin
              r_state <= StIdle;
              r_fcnt  <= '0;
            end
            StFlash: begin
              if (r_fcnt <= 6'd1) begin
                r_state <= StIdle;
                r_fcnt  <= '0;
              end else begin
                r_fcnt  <= r_fcnt - 6'd1;
              end
            end
            default: begin
              r_state <= StIdle;
              r_fcnt  <= '0;
            end
          endcase
        end
      end
    end

    assign w_shown[k] = r_shown;
    // Bit 3 of the countdown gives an 8-frame on / 8-frame off blink.
    assign w_blank[k] = (r_state == StFlash) && r_fcnt[3];
  end

  // ---------------------------------------------------------------------------
  // Stage 0: sprite hit test and ROM address
  // ---------------------------------------------------------------------------
  logic [31:0] w_x_ext;
  logic [31:0] w_y_ext;
  logic        w_in_rows;
  logic        w_vis_p1;
  logic        w_vis_p2;
  logic        w_vis;
  logic [3:0]  w_digit;
  logic [9:0]  w_col;
  logic [9:0]  w_row;
  logic        w_blank_sel;
  logic [15:0] w_addr;

  assign w_x_ext   = {22'd0, x};
  assign w_y_ext   = {22'd0, y};
  assign w_in_rows = (w_y_ext >= SCORE_Y) && (w_y_ext < SCORE_Y + HEIGHT);
  assign w_vis_p1  = w_in_rows && (w_x_ext >= P1_X) && (w_x_ext < P1_X + WIDTH);
  assign w_vis_p2  = w_in_rows && (w_x_ext >= P2_X) && (w_x_ext < P2_X + WIDTH);
  assign w_vis     = w_vis_p1 | w_vis_p2;

  // Player 1 has priority where the two windows overlap.
  always_comb begin
    w_digit     = w_shown[1];
    w_col       = x - P2X10;
    w_blank_sel = w_blank[1];
    if (w_vis_p1) begin
      w_digit     = w_shown[0];
      w_col       = x - P1X10;
      w_blank_sel = w_blank[0];
    end
  end

  assign w_row  = y - ScoreY10;
  // Only meaningful while w_vis is set, so row/col never underflow in use.
  assign w_addr = 16'(w_digit) * DigitSize + RowStride * 16'(w_row) + 16'(w_col);

  // ---------------------------------------------------------------------------
  // Stages 1..3: address register, flag delay line, output register
  // ---------------------------------------------------------------------------
  logic r_vis_s1;
  logic r_vis_s2;
  logic r_blank_s1;
  logic r_blank_s2;

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_addr   <= '0;
      r_vis_s1   <= 1'b0;
      r_vis_s2   <= 1'b0;
      r_blank_s1 <= 1'b0;
      r_blank_s2 <= 1'b0;
      pixel_out  <= '0;
    end else begin
      if (w_vis) begin
        rom_addr <= w_addr;
      end
      r_vis_s1   <= w_vis;
      r_blank_s1 <= w_blank_sel;
      r_vis_s2   <= r_vis_s1;
      r_blank_s2 <= r_blank_s1;
      pixel_out  <= (r_vis_s2 && !r_blank_s2) ? rom_data : 9'd0;
    end
  end

endmodule

// File: tb/tb_score_sprite_sched.sv
// -----------------------------------------------------------------------------
// Self-checking bench for score_sprite_sched. A behavioural model tracks shown
// digits, remaining blink frames and the 3-clock pixel latency; a compare
// process checks rom_addr and pixel_out every clock. Directed scans add
// hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_score_sprite_sched;

  localparam int P1X = 200;
  localparam int P2X = 385;
  localparam int SY  = 20;
  localparam int W   = 55;
  localparam int H   = 75;
  localparam int FF  = 60;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        vsync;
  logic [9:0]  x;
  logic [9:0]  y;
  logic [3:0]  sp1;
  logic [3:0]  sp2;
  logic [15:0] rom_addr;
  logic [8:0]  rom_data;
  logic [8:0]  pixel_out;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  score_sprite_sched dut (
    .pixel_clk (clk),
    .reset_n   (reset_n),
    .vsync     (vsync),
    .x         (x),
    .y         (y),
    .score_p1  (sp1),
    .score_p2  (sp2),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .pixel_out (pixel_out)
  );

  // Synthetic digit ROM contents.
  function automatic logic [8:0] romf(input int a);
    logic [15:0] t;
    t = 16'(a * 13 + 7);
    return t[8:0] ^ t[15:7];
  endfunction

  always @(posedge clk) rom_data <= romf(int'(rom_addr));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  int m_shown [2];
  int m_rem   [2];
  bit m_vs_prev;
  bit p_vis   [2];
  int p_addr  [2];
  bit p_blank [2];
  int exp_addr = 0;
  int exp_pix  = 0;

  always @(posedge clk) begin : model
    int xi, yi, sc, addr;
    bit vis, blk;
    if (!reset_n) begin
      for (int k = 0; k < 2; k++) begin
        m_shown[k] = 0; m_rem[k] = 0;
        p_vis[k] = 0; p_addr[k] = 0; p_blank[k] = 0;
      end
      m_vs_prev = 0;
      exp_addr  = 0;
      exp_pix   = 0;
    end else begin
      xi = int'(x); yi = int'(y);
      vis = 0; addr = 0; blk = 0;
      if (yi >= SY && yi < SY + H) begin
        if (xi >= P1X && xi < P1X + W) begin
          vis  = 1;
          addr = m_shown[0] * W * H + W * (yi - SY) + (xi - P1X);
          blk  = (m_rem[0] > 0) && ((m_rem[0] & 8) != 0);
        end else if (xi >= P2X && xi < P2X + W) begin
          vis  = 1;
          addr = m_shown[1] * W * H + W * (yi - SY) + (xi - P2X);
          blk  = (m_rem[1] > 0) && ((m_rem[1] & 8) != 0);
        end
      end
      exp_pix = (p_vis[1] && !p_blank[1]) ? int'(romf(p_addr[1])) : 0;
      p_vis[1] = p_vis[0]; p_addr[1] = p_addr[0]; p_blank[1] = p_blank[0];
      p_vis[0] = vis;      p_addr[0] = addr;      p_blank[0] = blk;
      if (vis) exp_addr = addr;
      if (vsync && !m_vs_prev) begin
        for (int k = 0; k < 2; k++) begin
          sc = (k == 0) ? int'(sp1) : int'(sp2);
          if (sc > 9) sc = 9;
          if (sc != m_shown[k]) m_rem[k] = FF;
          else if (m_rem[k] > 0) m_rem[k] = m_rem[k] - 1;
          m_shown[k] = sc;
        end
      end
      m_vs_prev = vsync;
    end
  end

  always @(posedge clk) begin
    #2;
    check("cyc rom_addr", {16'd0, rom_addr}, exp_addr);
    check("cyc pixel_out", {23'd0, pixel_out}, exp_pix);
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      vsync = 1'b1; cyc(1);
      vsync = 1'b0; cyc(1);
    end
  endtask

  // Scan one pixel from a parked (invisible) position and check its address
  // one clock later and its output exactly three clocks later.
  task automatic scan(input string name, input int xx, input int yy, input int ea,
                      input int ep);
    x = 10'(xx); y = 10'(yy);
    cyc(1);
    check({name, " addr"}, {16'd0, rom_addr}, ea);
    x = '0; y = '0;
    cyc(1);
    check({name, " early"}, {23'd0, pixel_out}, 0);
    cyc(1);
    check({name, " pix"}, {23'd0, pixel_out}, ep);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; vsync = 1'b0; x = '0; y = '0; sp1 = '0; sp2 = '0;
    cyc(3);
    check("reset rom_addr", {16'd0, rom_addr}, 0);
    check("reset pixel_out", {23'd0, pixel_out}, 0);
    reset_n = 1'b1;
    cyc(2);
    frames(1);

    // Scores 0/0: top-left of player 1 digit 0.
    scan("p1 origin", P1X, SY, 0, int'(romf(0)));

    // Player 2 to 7: address 7*4125+110+10, blanked at the start of its blink.
    sp2 = 4'd7;
    frames(1);
    scan("p2 seven", P2X + 10, SY + 2, 28995, 0);

    // Out-of-range score clamps to 9.
    sp1 = 4'd12;
    frames(1);
    scan("p1 clamp", P1X, SY, 37125, 0);

    // Outside both windows: address held, output transparent.
    x = '0; y = '0;
    cyc(1);
    check("outside addr", {16'd0, rom_addr}, 37125);
    cyc(2);
    check("outside pix", {23'd0, pixel_out}, 0);

    // Player 1 3 -> 4 with a full blink cycle.
    sp1 = 4'd3;
    frames(1);
    frames(60);
    scan("p1 three idle", P1X, SY, 12375, int'(romf(12375)));
    sp1 = 4'd4;
    scan("p1 old digit", P1X, SY, 12375, int'(romf(12375)));
    frames(1);
    scan("p1 flash 60", P1X, SY, 16500, 0);
    frames(52);
    scan("p1 flash 8", P1X, SY, 16500, 0);
    frames(4);
    scan("p1 flash 4", P1X, SY, 16500, int'(romf(16500)));
    frames(4);
    scan("p1 idle again", P1X, SY, 16500, int'(romf(16500)));

    // Reset during a player 2 blink with the pipeline full of visible pixels.
    sp2 = 4'd2;
    frames(1);
    x = 10'(P1X + 5); y = 10'(SY + 5);
    cyc(3);
    reset_n = 1'b0;
    #1;
    check("midreset pix", {23'd0, pixel_out}, 0);
    check("midreset addr", {16'd0, rom_addr}, 0);
    cyc(2);
    reset_n = 1'b1;
    cyc(1);
    check("release pix1", {23'd0, pixel_out}, 0);
    check("release addr", {16'd0, rom_addr}, 280);
    cyc(1);
    check("release pix2", {23'd0, pixel_out}, 0);
    cyc(1);
    check("release pix3", {23'd0, pixel_out}, int'(romf(280)));
    x = '0; y = '0;
    cyc(2);
    scan("p2 idle after reset", P2X + 1, SY + 1, 56, int'(romf(56)));

    // Randomised scan, scores, vsync and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        x = 10'($urandom_range(P1X - 5, P2X + W + 5));
        y = 10'($urandom_range(SY - 5, SY + H + 5));
      end else begin
        x = 10'($urandom_range(0, 1023));
        y = 10'($urandom_range(0, 1023));
      end
      vsync = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 99) == 0) sp1 = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 99) == 0) sp2 = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 599) == 0) begin
        reset_n = 1'b0;
        cyc(1 + int'($urandom_range(0, 2)));
        reset_n = 1'b1;
      end
      cyc(1);
    end

    cyc(4);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/score_sprite_sched.md
SCORE_SPRITE_SCHED -- requirements
Module: score_sprite_sched

Interface
REQ-001 SHALL have parameter P1_X, default 200, left-digit sprite x origin.
REQ-002 SHALL have parameter P2_X, default 385, right-digit sprite x origin.
REQ-003 SHALL have parameter SCORE_Y, default 20, y origin of both digits.
REQ-004 SHALL have parameter WIDTH, default 55, sprite width in pixels.
REQ-005 SHALL have parameter HEIGHT, default 75, sprite height in pixels.
REQ-006 SHALL have parameter FLASH_FRAMES, default 60, frames a changed digit blinks.
REQ-007 SHALL have port pixel_clk  in  1  the single clock; all state on its rising edge.
REQ-008 SHALL have port reset_n  in  1  asynchronous active-low reset.
REQ-009 SHALL have port vsync  in  1  active-high frame sync level.
REQ-010 SHALL have port x, y  in  10 each  current scan pixel position.
REQ-011 SHALL have port score_p1, score_p2  in  4 each  live player scores.
REQ-012 SHALL have port rom_addr  out  16  address to the shared digit ROM (10 stacked images of WIDTH*HEIGHT).
REQ-013 SHALL have port rom_data  in  9  ROM pixel, valid one cycle after rom_addr is sampled.
REQ-014 SHALL have port pixel_out  out  9  composited score pixel, 0 when transparent.

Function
REQ-015 SHALL assert frame_start for one cycle when sampled vsync is 1 and the previous sample is 0.
REQ-016 SHALL latch score_p1/score_p2 into shown_p1/shown_p2 only on frame_start; values above 9 are clamped to 9.
REQ-017 SHALL define sprite k as visible when X_k <= x < X_k+WIDTH and SCORE_Y <= y < SCORE_Y+HEIGHT; if both are visible, P1 wins.
REQ-018 SHALL register rom_addr = shown_k*WIDTH*HEIGHT + WIDTH*(y-SCORE_Y) + (x-X_k) for the visible sprite, 16-bit unsigned, no wrap for legal values (max 41249).
REQ-019 SHALL hold rom_addr at its previous value when no sprite is visible.
REQ-020 SHALL delay the visible and blank flags by 2 cycles and register pixel_out = rom_data when the delayed visible flag is set and blank is clear, else 0.
REQ-021 SHALL give a fixed latency of 3 cycles from x,y to the corresponding pixel_out.
REQ-022 SHALL run an independent flash FSM per player with states IDLE and FLASH and a 6-bit frame counter fcnt.
REQ-023 SHALL transition IDLE->FLASH on frame_start when the newly latched score differs from the old shown value, loading fcnt=FLASH_FRAMES.
REQ-024 SHALL, in FLASH, decrement fcnt on each frame_start, transition to IDLE when fcnt reaches 0, and reload FLASH_FRAMES on a further score change.
REQ-025 SHALL blank the player's digit while in FLASH and fcnt[3]=1, and never blank it in IDLE.
REQ-026 SHALL not treat the first frame_start after reset as a change if the scores equal 0.

Reset
REQ-027 SHALL, while reset_n=0 (asynchronously), force shown_p1=shown_p2=0, both FSMs to IDLE, fcnt=0, the vsync history to 0, pipeline flags to 0, rom_addr=0, and pixel_out=0.
REQ-028 SHALL, on release, resume from the reset state on the next rising pixel_clk, with pixel_out 0 for at least 3 cycles.
REQ-029 SHALL, on a mid-frame reset, discard pending pipeline pixels and any FLASH state.

Verification
REQ-030 Bench SHALL cover: reset, then scores 0/0 and a scan of pixel (P1_X,SCORE_Y) -> rom_addr=0 and pixel_out=rom_data exactly 3 cycles later.
REQ-031 Bench SHALL cover: score_p2=7 at pixel (P2_X+10,SCORE_Y+2) after frame_start -> rom_addr=7*4125+110+10=28995.
REQ-032 Bench SHALL cover: score_p1 changing 3->4 mid-frame -> the old digit is shown until the next vsync rise, then FLASH with fcnt=60, the digit blanked (60 has bit3=1), and IDLE after 60 frame_starts.
REQ-033 Bench SHALL cover: score_p1=12 -> shown_p1=9 and rom_addr base 37125.
REQ-034 Bench SHALL cover: pixel outside both windows, e.g. (0,0) -> pixel_out=0 and rom_addr unchanged.
REQ-035 Bench SHALL cover: reset_n low during FLASH and mid-scan -> immediate pixel_out=0 and FSM IDLE, with no output glitch after release.
